// File: rtl/apb_slave_mem_pkg.sv
// Shared types and the address decoder for the APB slave memory responder.
package apb_slave_mem_pkg;

  localparam int WAIT_W   = 4;
  localparam int ERRCNT_W = 8;
  localparam int DEC_W    = 64;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef enum logic [1:0] {
    AK_MEM,
    AK_CFG,
    AK_ERRCNT,
    AK_INVALID
  } addr_kind_t;

  // Addresses are widened to DEC_W so the compare works for any bus width.
  function automatic addr_kind_t addr_kind(
    input logic [DEC_W-1:0] paddr,
    input logic [DEC_W-1:0] mem_depth,
    input logic [DEC_W-1:0] cfg_addr
  );
    addr_kind_t kind;
    if (paddr < mem_depth) begin
      kind = AK_MEM;
    end else if (paddr == cfg_addr) begin
      kind = AK_CFG;
    end else if (paddr == cfg_addr + DEC_W'(1)) begin
      kind = AK_ERRCNT;
    end else begin
      kind = AK_INVALID;
    end
    return kind;
  endfunction

endpackage

// File: rtl/apb_slave_mem_array.sv
// Word storage: synchronous write, asynchronous read, cleared by reset.
module apb_slave_mem_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             pclock,
  input  logic             preset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave responder: byte memory, wait-state config register and error counter.
//
// state  | meaning
// IDLE   | no transfer; a setup phase (psel & !penable) is latched here
// ACCESS | access phase; wcnt counts down wait states, pready when it hits 0
module apb_slave_mem
  import apb_slave_mem_pkg::*;
#(
  parameter int                     PADDR_WIDTH  = 32,
  parameter int                     PWDATA_WIDTH = 8,
  parameter int                     PRDATA_WIDTH = PWDATA_WIDTH,
  parameter int                     MEM_DEPTH    = 256,
  parameter int                     DEFAULT_WAIT = 0,
  parameter logic [PADDR_WIDTH-1:0] CFG_ADDR     = 32'h0000_1000
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic [PADDR_WIDTH-1:0]  paddr,
  input  logic                    prwd,
  input  logic [PWDATA_WIDTH-1:0] pwdata,
  input  logic                    psel,
  input  logic                    penable,
  output logic [PRDATA_WIDTH-1:0] prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_t                    state_q, state_d;
  logic [WAIT_W-1:0]         wcnt_q;
  logic [WAIT_W-1:0]         wait_cfg;
  logic [ERRCNT_W-1:0]       err_cnt;
  addr_kind_t                kind_q;
  addr_kind_t                kind_in;
  logic                      wr_q;
  logic                      err_q;
  logic [AW-1:0]             idx_q;
  logic [PWDATA_WIDTH-1:0]   wdata_q;
  logic [PRDATA_WIDTH-1:0]   rdata_q;
  logic [PRDATA_WIDTH-1:0]   rd_sel;
  logic [PWDATA_WIDTH-1:0]   mem_rdata;
  logic                      setup;
  logic                      pready_c;
  logic                      complete;
  logic                      mem_we;
  logic                      cfg_we;
  logic                      errcnt_clr;
  logic                      errcnt_inc;

  assign setup   = psel & ~penable;
  assign kind_in = addr_kind(DEC_W'(paddr), DEC_W'(MEM_DEPTH), DEC_W'(CFG_ADDR));

  apb_slave_mem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (PWDATA_WIDTH),
    .AW    (AW)
  ) u_array (
    .pclock (pclock),
    .preset (preset),
    .we     (mem_we),
    .waddr  (idx_q),
    .wdata  (wdata_q),
    .raddr  (paddr[AW-1:0]),
    .rdata  (mem_rdata)
  );

  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pready_c = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        pready_c = (wcnt_q == '0);
        if (!psel) begin
          state_d = IDLE;
        end else if (penable && pready_c) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is snapshotted at setup so the access phase sees a stable value.
  always_comb begin
    case (kind_in)
      AK_MEM:    rd_sel = PRDATA_WIDTH'(mem_rdata);
      AK_CFG:    rd_sel = PRDATA_WIDTH'(wait_cfg);
      AK_ERRCNT: rd_sel = PRDATA_WIDTH'(err_cnt);
      default:   rd_sel = '0;
    endcase
  end

  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      wcnt_q  <= '0;
      kind_q  <= AK_MEM;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (state_q == IDLE && setup) begin
      wcnt_q  <= wait_cfg;
      kind_q  <= kind_in;
      wr_q    <= prwd;
      err_q   <= (kind_in == AK_INVALID);
      idx_q   <= paddr[AW-1:0];
      wdata_q <= pwdata;
      rdata_q <= rd_sel;
    end else if (state_q == ACCESS && psel && penable && wcnt_q != '0) begin
      wcnt_q  <= wcnt_q - WAIT_W'(1);
    end
  end

  assign mem_we     = complete & wr_q & (kind_q == AK_MEM);
  assign cfg_we     = complete & wr_q & (kind_q == AK_CFG);
  assign errcnt_clr = complete & wr_q & (kind_q == AK_ERRCNT);
  assign errcnt_inc = complete & err_q & (err_cnt != '1);

  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      wait_cfg <= WAIT_W'(DEFAULT_WAIT);
      err_cnt  <= '0;
    end else begin
      if (cfg_we) begin
        wait_cfg <= wdata_q[WAIT_W-1:0];
      end
      // Clear takes priority over a coincident error increment.
      if (errcnt_clr) begin
        err_cnt <= '0;
      end else if (errcnt_inc) begin
        err_cnt <= err_cnt + ERRCNT_W'(1);
      end
    end
  end

  assign pready  = pready_c;
  assign pslverr = pready_c & err_q;
  assign prdata  = (pready_c && !wr_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed self-checking bench for apb_slave_mem.
module tb_apb_slave_mem;

  localparam logic [31:0] CFG = 32'h0000_1000;
  localparam logic [31:0] ERR = 32'h0000_1001;

  logic        pclock;
  logic        preset;
  logic [31:0] paddr;
  logic        prwd;
  logic [7:0]  pwdata;
  logic        psel;
  logic        penable;
  logic [7:0]  prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  apb_slave_mem dut (
    .pclock  (pclock),
    .preset  (preset),
    .paddr   (paddr),
    .prwd    (prwd),
    .pwdata  (pwdata),
    .psel    (psel),
    .penable (penable),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  initial pclock = 1'b0;
  always #5 pclock = ~pclock;

  // Entered and left just after a rising edge, so transfers chain back-to-back.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output logic err, output int cyc);
    bit done;
    done = 0;
    rd = 8'h00;
    err = 1'b0;
    psel = 1'b1; penable = 1'b0; prwd = wr; paddr = addr; pwdata = wd;
    cyc = 1;
    @(posedge pclock); #1;
    penable = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclock);
      cyc++;
      if (pready) begin
        rd = prdata;
        err = pslverr;
        done = 1;
      end
      @(posedge pclock); #1;
    end
    psel = 1'b0; penable = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: addr %h got no pready, required pready=1 within 40 cycles", addr);
    end
  endtask

  task automatic test_reset();
    preset = 1'b0; psel = 1'b0; penable = 1'b0; prwd = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge pclock);
    #1;
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL rst_pready: got %b exp 0", pready); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b exp 0", pslverr); end
    checks++; if (prdata !== 8'h00) begin errors++; $display("FAIL rst_prdata: got %h exp 00", prdata); end
    preset = 1'b1;
    @(posedge pclock); #1;
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL idle_pready: got %b exp 0", pready); end
  endtask

  task automatic test_basic_rw();
    logic [7:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 32'h10, 8'hA5, rd, err, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL wr10_cycles: got %0d exp 2", cyc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr10_err: got %b exp 0", err); end
    apb_xfer(1'b0, 32'h10, 8'h00, rd, err, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL rd10_cycles: got %0d exp 2", cyc); end
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL rd10_data: got %h exp a5", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd10_err: got %b exp 0", err); end
  endtask

  task automatic test_wait_states();
    logic [7:0] rd; logic err; int cyc;
    apb_xfer(1'b1, CFG, 8'h03, rd, err, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL wrcfg_cycles: got %0d exp 2", cyc); end
    apb_xfer(1'b0, 32'h10, 8'h00, rd, err, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL rd10_w3_cycles: got %0d exp 5", cyc); end
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL rd10_w3_data: got %h exp a5", rd); end
    apb_xfer(1'b0, CFG, 8'h00, rd, err, cyc);
    checks++; if (rd !== 8'h03) begin errors++; $display("FAIL rdcfg_data: got %h exp 03", rd); end
  endtask

  task automatic test_invalid();
    logic [7:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 32'h200, 8'h55, rd, err, cyc);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wr200_err: got %b exp 1", err); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL wr200_cycles: got %0d exp 5", cyc); end
    apb_xfer(1'b0, ERR, 8'h00, rd, err, cyc);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL errcnt_1: got %h exp 01", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rderr_err: got %b exp 0", err); end
    apb_xfer(1'b0, 32'h00, 8'h00, rd, err, cyc);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rd00_data: got %h exp 00", rd); end
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic err; int cyc;
    bit seen;
    seen = 0;
    psel = 1'b1; penable = 1'b0; prwd = 1'b0; paddr = 32'h10;
    @(posedge pclock); #1;
    penable = 1'b1;
    @(negedge pclock);
    if (pready) seen = 1;
    @(posedge pclock); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclock);
      if (pready) seen = 1;
    end
    @(posedge pclock); #1;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_pready: got pready seen=%b exp 0", seen); end
    apb_xfer(1'b0, ERR, 8'h00, rd, err, cyc);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL abort_errcnt: got %h exp 01", rd); end
    apb_xfer(1'b0, 32'h10, 8'h00, rd, err, cyc);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL abort_rd10: got %h exp a5", rd); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL abort_rd10_cycles: got %0d exp 5", cyc); end
  endtask

  task automatic test_saturation();
    logic [7:0] rd; logic err; int cyc;
    int bad;
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      apb_xfer(1'b0, 32'h300, 8'h00, rd, err, cyc);
      if (err !== 1'b1 || rd !== 8'h00) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL invalid_reads: got %0d bad responses exp 0", bad); end
    apb_xfer(1'b0, ERR, 8'h00, rd, err, cyc);
    checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL errcnt_sat: got %h exp ff", rd); end
    apb_xfer(1'b1, ERR, 8'h5A, rd, err, cyc);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL errclr_err: got %b exp 0", err); end
    apb_xfer(1'b0, ERR, 8'h00, rd, err, cyc);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL errcnt_clr: got %h exp 00", rd); end
  endtask

  task automatic test_reset_mid_xfer();
    logic [7:0] rd; logic err; int cyc;
    psel = 1'b1; penable = 1'b0; prwd = 1'b1; paddr = 32'h20; pwdata = 8'h77;
    @(posedge pclock); #1;
    penable = 1'b1;
    @(negedge pclock);
    preset = 1'b0;
    #1;
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL midrst_pready: got %b exp 0", pready); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL midrst_pslverr: got %b exp 0", pslverr); end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclock); #1;
    preset = 1'b1;
    @(posedge pclock); #1;
    apb_xfer(1'b0, 32'h20, 8'h00, rd, err, cyc);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL midrst_rd20: got %h exp 00", rd); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL midrst_cycles: got %0d exp 2", cyc); end
    apb_xfer(1'b0, CFG, 8'h00, rd, err, cyc);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL midrst_cfg: got %h exp 00", rd); end
    apb_xfer(1'b0, 32'h10, 8'h00, rd, err, cyc);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL midrst_rd10: got %h exp 00", rd); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_wait_states();
    test_invalid();
    test_abort();
    test_saturation();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
